// File: rtl/div_pkg.sv
// div_pkg: state encoding, word constants and sign helper shared by the divider.
package div_pkg;
  localparam int unsigned REG_W = 32;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_W-1:0] ALL_ONES = '1;
  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;
  function automatic logic [REG_W-1:0] neg_if(input logic n, input logic [REG_W-1:0] v);
    return n ? ZERO_WORD - v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step on the {remainder, quotient} pair.
module div_step
  import div_pkg::*;
(
  input  logic [REG_W-1:0] r_i,
  input  logic [REG_W-1:0] q_i,
  input  logic [REG_W-1:0] divisor_i,
  output logic [REG_W-1:0] r_o,
  output logic [REG_W-1:0] q_o
);
  logic [REG_W:0] r_sh;
  logic ge;
  assign r_sh = {r_i, q_i[REG_W-1]};
  assign ge = r_sh >= {1'b0, divisor_i};
  // when ge holds the true difference is below the divisor, so 32-bit wraparound is exact
  assign r_o = ge ? r_sh[REG_W-1:0] - divisor_i : r_sh[REG_W-1:0];
  assign q_o = {q_i[REG_W-2:0], ge};
endmodule

// File: rtl/div.sv
// div: multi-cycle RV32M divider, result {remainder, quotient}; DIV_EARLY_OUT_EN skips the loop when |dividend| < |divisor|.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  div_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d, r_step, q_step, op1_abs, op2_abs;
  logic qneg_q, qneg_d, rneg_q, rneg_d, ready_q, ready_d, early;
  logic [63:0] result_q, result_d;
  assign op1_abs = neg_if(signed_div_i & opdata1_i[31], opdata1_i);
  assign op2_abs = neg_if(signed_div_i & opdata2_i[31], opdata2_i);
`ifdef DIV_EARLY_OUT_EN
  assign early = op1_abs < op2_abs;
`else
  assign early = 1'b0;
`endif
  div_step u_step (.r_i(r_q), .q_i(q_q), .divisor_i(dvs_q), .r_o(r_step), .q_o(q_step));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    result_d = result_q;
    ready_d = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d = 1'b0;
        if (start_i && !annul_i) begin
          qneg_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          rneg_d = signed_div_i & opdata1_i[31];
          dvs_d = op2_abs;
          cnt_d = '0;
          r_d = ZERO_WORD;
          q_d = op1_abs;
          if (opdata2_i == ZERO_WORD) begin
            state_d = DIV_BY_ZERO;
            r_d = opdata1_i;
          end else if (early) begin
            state_d = DIV_END;
            result_d = {opdata1_i, ZERO_WORD};
            ready_d = 1'b1;
          end else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d = annul_i ? DIV_FREE : DIV_END;
        result_d = annul_i ? '0 : {r_q, ALL_ONES};
        ready_d = !annul_i;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          r_d = r_step;
          q_d = q_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DIV_END;
            result_d = {neg_if(rneg_q, r_step), neg_if(qneg_q, q_step)};
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        if (annul_i || !start_i) begin
          state_d = DIV_FREE;
          result_d = '0;
          ready_d = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      result_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      result_q <= result_d;
      ready_q <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o = ready_q;
endmodule
